// File: rtl/tcore_param.sv
// Core-wide types shared by the fetch/decode boundary: exceptions, instruction
// classes, prediction info and the fetch queue entry, plus parameter checks.
package tcore_param;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    NO_EXCEPTION          = 4'd0,
    INSTR_ADDR_MISALIGNED = 4'd1,
    INSTR_ACCESS_FAULT    = 4'd2,
    ILLEGAL_INSTRUCTION   = 4'd3,
    BREAKPOINT            = 4'd4,
    INSTR_PAGE_FAULT      = 4'd5
  } exc_type_e;

  typedef enum logic [2:0] {
    ITYPE_NONE   = 3'd0,
    ITYPE_BRANCH = 3'd1,
    ITYPE_JAL    = 3'd2,
    ITYPE_JALR   = 3'd3,
    ITYPE_CALL   = 3'd4,
    ITYPE_RET    = 3'd5
  } instr_type_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_info_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_comp;
    exc_type_e       exc;
    instr_type_e     itype;
    predict_info_t   spec;
  } fetch_entry_t;

  function automatic bit fq_depth_ok(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit fq_af_level_ok(int af_level, int depth);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Fetch queue control: pointers, occupancy, bypass decision, fault fence and
// flush. Entry payload lives in the parent.
module fq_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter bit BYPASS   = 1'b1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          enq_valid_i,
  input  logic          deq_ready_i,
  input  logic          enq_exc_i,
  input  logic          head_exc_i,
  output logic          enq_ready_o,
  output logic          deq_valid_o,
  output logic          bypass_hit_o,
  output logic          wr_en_o,
  output logic [PW-1:0] wptr_o,
  output logic [PW-1:0] rptr_o,
  output logic [CW-1:0] count_o,
  output logic          afull_o,
  output logic          fence_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          fence_q;
  logic          full, empty, enq_fire, deq_fire, bypass_taken, rd_en;

  // Handshake: a transfer fires only on valid & ready in the same cycle;
  // enq_ready never depends on deq_ready, so a full queue refuses enq even
  // when the head is leaving this cycle.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign enq_ready_o  = !full && !fence_q && !flush_i;
  assign enq_fire     = enq_valid_i && enq_ready_o;
  assign bypass_hit_o = BYPASS && enq_fire && empty;
  assign deq_valid_o  = (!empty || bypass_hit_o) && !flush_i;
  assign deq_fire     = deq_valid_o && deq_ready_i;
  assign bypass_taken = bypass_hit_o && deq_fire;
  // A bypassed entry consumed this cycle never touches storage.
  assign wr_en_o      = enq_fire && !bypass_taken;
  assign rd_en        = deq_fire && !bypass_taken;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fence_q <= 1'b0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fence_q <= 1'b0;
    end else begin
      if (wr_en_o) wptr_q <= wptr_q + PW'(1);
      if (rd_en)   rptr_q <= rptr_q + PW'(1);
      if (wr_en_o && !rd_en)      count_q <= count_q + CW'(1);
      else if (rd_en && !wr_en_o) count_q <= count_q - CW'(1);
      // A stored fault blocks enq, so set and clear never coincide.
      if (wr_en_o && enq_exc_i)     fence_q <= 1'b1;
      else if (rd_en && head_exc_i) fence_q <= 1'b0;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;
  assign afull_o = (count_q >= AF_CNT);
  assign fence_o = fence_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode with optional empty bypass,
// almost-full throttle and a fence that stops fetch behind a faulting entry.
module fetch_queue
  import tcore_param::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter bit BYPASS   = 1'b1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         enq_valid_i,
  output logic         enq_ready_o,
  input  fetch_entry_t enq_entry_i,
  output logic         deq_valid_o,
  input  logic         deq_ready_i,
  output fetch_entry_t deq_entry_o,
  output logic [CW-1:0] count_o,
  output logic         afull_o,
  output logic         fence_o
);

  if (!fq_depth_ok(DEPTH)) begin : g_depth_chk
    $error("fetch_queue: DEPTH must be a power of two >= 2");
  end
  if (!fq_af_level_ok(AF_LEVEL, DEPTH)) begin : g_af_chk
    $error("fetch_queue: AF_LEVEL must lie in 1..DEPTH");
  end

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          wr_en, bypass_hit;
  logic          enq_exc, head_exc;

  assign enq_exc  = (enq_entry_i.exc != NO_EXCEPTION);
  assign head_exc = (mem[rptr].exc != NO_EXCEPTION);

  fq_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .BYPASS   (BYPASS)
  ) u_ctrl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .enq_valid_i  (enq_valid_i),
    .deq_ready_i  (deq_ready_i),
    .enq_exc_i    (enq_exc),
    .head_exc_i   (head_exc),
    .enq_ready_o  (enq_ready_o),
    .deq_valid_o  (deq_valid_o),
    .bypass_hit_o (bypass_hit),
    .wr_en_o      (wr_en),
    .wptr_o       (wptr),
    .rptr_o       (rptr),
    .count_o      (count_o),
    .afull_o      (afull_o),
    .fence_o      (fence_o)
  );

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= enq_entry_i;
  end

  // Storage is not reset, so an empty queue presents an all-zero entry.
  always_comb begin
    deq_entry_o = '0;
    if (bypass_hit)          deq_entry_o = enq_entry_i;
    else if (count_o != '0)  deq_entry_o = mem[rptr];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, AF_LEVEL=3, BYPASS=1): vector table
// plus hand sequences for full throughput, flush and async reset.
module tb_fetch_queue;
  import tcore_param::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [31:0] B = 32'h8000_0000;

  logic         clk_i = 1'b0;
  logic         rst_ni, flush_i, enq_valid_i, deq_ready_i;
  logic         enq_ready_o, deq_valid_o, afull_o, fence_o;
  logic [CW-1:0] count_o;
  fetch_entry_t enq_entry_i, deq_entry_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    exc_type_e   exc;
    logic        dr;
    logic        x_dv;
    logic [31:0] x_pc;
    exc_type_e   x_exc;
    logic [CW-1:0] x_cnt;
    logic        x_er;
    logic        x_af;
    logic        x_fe;
  } vec_t;
  vec_t vt[$];

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  fetch_queue #(.DEPTH(DEPTH), .AF_LEVEL(3), .BYPASS(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_entry_i (enq_entry_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_entry_o (deq_entry_o),
    .count_o     (count_o),
    .afull_o     (afull_o),
    .fence_o     (fence_o)
  );

  function automatic fetch_entry_t make_entry(logic [31:0] pc, exc_type_e exc);
    fetch_entry_t e;
    e             = '0;
    e.pc          = pc;
    e.inst        = ~pc;
    e.is_comp     = pc[2];
    e.exc         = exc;
    e.itype       = ITYPE_BRANCH;
    e.spec.taken  = pc[3];
    e.spec.target = pc + 32'h40;
    return e;
  endfunction

  // scoreboard helpers
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_entry(string name, fetch_entry_t act, fetch_entry_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%0h exc=%0d inst=%0h expected pc=%0h exc=%0d inst=%0h",
               name, act.pc, act.exc, act.inst, exp.pc, exp.exc, exp.inst);
    end
  endtask

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive(logic ev, logic [31:0] pc, exc_type_e exc, logic dr, logic fl);
    @(posedge clk_i);
    #1;
    enq_valid_i = ev;
    enq_entry_i = ev ? make_entry(pc, exc) : '0;
    deq_ready_i = dr;
    flush_i     = fl;
  endtask

  task automatic add(logic ev, logic [31:0] pc, exc_type_e exc, logic dr,
                     logic x_dv, logic [31:0] x_pc, exc_type_e x_exc,
                     logic [CW-1:0] x_cnt, logic x_er, logic x_af, logic x_fe);
    vec_t v;
    v.ev = ev; v.pc = pc; v.exc = exc; v.dr = dr;
    v.x_dv = x_dv; v.x_pc = x_pc; v.x_exc = x_exc; v.x_cnt = x_cnt;
    v.x_er = x_er; v.x_af = x_af; v.x_fe = x_fe;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] next_pc;
    int          mcount;
    logic        exp_er;

    rst_ni = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    enq_entry_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready_o), 32'd1);
    chk("rst_afull", 32'(afull_o), 32'd0);
    chk("rst_fence", 32'(fence_o), 32'd0);
    chk_entry("rst_deq_entry", deq_entry_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ev pc exc dr | dv pc exc cnt er af fe   (outputs seen before the edge)
    add(0, 0,       NO_EXCEPTION,        0, 0, 0,       NO_EXCEPTION,        0, 1, 0, 0);
    add(1, B,       NO_EXCEPTION,        1, 1, B,       NO_EXCEPTION,        0, 1, 0, 0);
    add(0, 0,       NO_EXCEPTION,        0, 0, 0,       NO_EXCEPTION,        0, 1, 0, 0);
    add(1, B,       NO_EXCEPTION,        0, 1, B,       NO_EXCEPTION,        0, 1, 0, 0);
    add(1, B+4,     NO_EXCEPTION,        0, 1, B,       NO_EXCEPTION,        1, 1, 0, 0);
    add(1, B+8,     NO_EXCEPTION,        0, 1, B,       NO_EXCEPTION,        2, 1, 0, 0);
    add(1, B+'hC,   NO_EXCEPTION,        0, 1, B,       NO_EXCEPTION,        3, 1, 1, 0);
    add(1, B+'h10,  NO_EXCEPTION,        0, 1, B,       NO_EXCEPTION,        4, 0, 1, 0);
    add(0, 0,       NO_EXCEPTION,        1, 1, B,       NO_EXCEPTION,        4, 0, 1, 0);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+4,     NO_EXCEPTION,        3, 1, 1, 0);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+8,     NO_EXCEPTION,        2, 1, 0, 0);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+'hC,   NO_EXCEPTION,        1, 1, 0, 0);
    add(0, 0,       NO_EXCEPTION,        0, 0, 0,       NO_EXCEPTION,        0, 1, 0, 0);
    add(1, B+'h20,  NO_EXCEPTION,        0, 1, B+'h20,  NO_EXCEPTION,        0, 1, 0, 0);
    add(1, B+'h24,  NO_EXCEPTION,        0, 1, B+'h20,  NO_EXCEPTION,        1, 1, 0, 0);
    add(1, B+'h28,  ILLEGAL_INSTRUCTION, 0, 1, B+'h20,  NO_EXCEPTION,        2, 1, 0, 0);
    add(1, B+'h2C,  NO_EXCEPTION,        0, 1, B+'h20,  NO_EXCEPTION,        3, 0, 1, 1);
    add(1, B+'h2C,  NO_EXCEPTION,        1, 1, B+'h20,  NO_EXCEPTION,        3, 0, 1, 1);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+'h24,  NO_EXCEPTION,        2, 0, 0, 1);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+'h28,  ILLEGAL_INSTRUCTION, 1, 0, 0, 1);
    add(1, B+'h2C,  NO_EXCEPTION,        0, 1, B+'h2C,  NO_EXCEPTION,        0, 1, 0, 0);
    add(0, 0,       NO_EXCEPTION,        1, 1, B+'h2C,  NO_EXCEPTION,        1, 1, 0, 0);
    add(1, B+'h30,  ILLEGAL_INSTRUCTION, 1, 1, B+'h30,  ILLEGAL_INSTRUCTION, 0, 1, 0, 0);
    add(0, 0,       NO_EXCEPTION,        0, 0, 0,       NO_EXCEPTION,        0, 1, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ev, vt[i].pc, vt[i].exc, vt[i].dr, 1'b0);
      @(negedge clk_i);
      chk($sformatf("v%0d deq_valid", i), 32'(deq_valid_o), 32'(vt[i].x_dv));
      chk($sformatf("v%0d count", i), 32'(count_o), 32'(vt[i].x_cnt));
      chk($sformatf("v%0d enq_ready", i), 32'(enq_ready_o), 32'(vt[i].x_er));
      chk($sformatf("v%0d afull", i), 32'(afull_o), 32'(vt[i].x_af));
      chk($sformatf("v%0d fence", i), 32'(fence_o), 32'(vt[i].x_fe));
      chk_entry($sformatf("v%0d deq_entry", i), deq_entry_o,
                vt[i].x_dv ? make_entry(vt[i].x_pc, vt[i].x_exc) : '0);
    end

    // full queue with enq and deq held high for 16 cycles
    next_pc = B + 32'h200;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, next_pc, NO_EXCEPTION, 1'b0, 1'b0);
      @(negedge clk_i);
      chk($sformatf("fill%0d enq_ready", k), 32'(enq_ready_o), 32'd1);
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
    mcount = DEPTH;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, next_pc, NO_EXCEPTION, 1'b1, 1'b0);
      @(negedge clk_i);
      exp_er = (mcount != DEPTH);
      chk($sformatf("thru%0d enq_ready", c), 32'(enq_ready_o), 32'(exp_er));
      chk($sformatf("thru%0d deq_valid", c), 32'(deq_valid_o), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL thru%0d: dequeued pc=%0h with empty expected queue", c, deq_entry_o.pc);
      end else begin
        chk($sformatf("thru%0d pc", c), deq_entry_o.pc, exp_q.pop_front());
      end
      if (exp_er) begin
        exp_q.push_back(next_pc);
        next_pc += 32'd4;
      end else begin
        mcount--;
      end
    end
    for (int d = 0; d < 8; d++) begin
      drive(1'b0, 32'd0, NO_EXCEPTION, 1'b1, 1'b0);
      @(negedge clk_i);
      if (!deq_valid_o) break;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL drain%0d: extra entry pc=%0h", d, deq_entry_o.pc);
      end else begin
        chk($sformatf("drain%0d pc", d), deq_entry_o.pc, exp_q.pop_front());
      end
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(count_o), 32'd0);

    // flush with three entries stored and the fence set
    drive(1'b1, B+'h40, NO_EXCEPTION, 1'b0, 1'b0);
    drive(1'b1, B+'h44, NO_EXCEPTION, 1'b0, 1'b0);
    drive(1'b1, B+'h48, ILLEGAL_INSTRUCTION, 1'b0, 1'b0);
    drive(1'b1, B+'h4C, NO_EXCEPTION, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("flush_pre_count", 32'(count_o), 32'd3);
    chk("flush_pre_fence", 32'(fence_o), 32'd1);
    chk("flush_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("flush_enq_ready", 32'(enq_ready_o), 32'd0);
    drive(1'b0, 32'd0, NO_EXCEPTION, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("post_flush_count", 32'(count_o), 32'd0);
    chk("post_flush_fence", 32'(fence_o), 32'd0);
    chk("post_flush_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("post_flush_enq_ready", 32'(enq_ready_o), 32'd1);
    drive(1'b1, B+'h100, NO_EXCEPTION, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("post_flush_bypass_pc", deq_entry_o.pc, B+'h100);
    drive(1'b0, 32'd0, NO_EXCEPTION, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("post_flush_count1", 32'(count_o), 32'd1);
    chk_entry("post_flush_head", deq_entry_o, make_entry(B+'h100, NO_EXCEPTION));

    // asynchronous reset between edges with two entries stored
    drive(1'b1, B+'h60, NO_EXCEPTION, 1'b0, 1'b0);
    drive(1'b1, B+'h64, NO_EXCEPTION, 1'b0, 1'b0);
    drive(1'b0, 32'd0, NO_EXCEPTION, 1'b0, 1'b0);
    #2;
    chk("pre_areset_count", 32'(count_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("areset_count", 32'(count_o), 32'd0);
    chk("areset_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("areset_enq_ready", 32'(enq_ready_o), 32'd1);
    chk("areset_afull", 32'(afull_o), 32'd0);
    chk("areset_fence", 32'(fence_o), 32'd0);
    chk_entry("areset_deq_entry", deq_entry_o, '0);
    #10;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("after_areset_count", 32'(count_o), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
